stack_exec: RTL and testbench
=============================

STACK_EXEC -- requirements
Module: stack_exec

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of operand-stack entries (16 entries of 16 bits).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1, command offered.
REQ-005 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-006 SHALL have port cmd_op, input, 3, opcode: 000 NOP, 001 PUSH, 010 POP, 011 EXEC, 100 DUP (see Configuration); 101-111 illegal.
REQ-007 SHALL have port cmd_data, input, 16, PUSH operand.
REQ-008 SHALL have port cmd_func, input, 5, ALU function code for EXEC; 0-15 binary, 16-18 unary (NEG, BNOT, NOT), 19-31 illegal.
REQ-009 SHALL have ports alu_a, alu_b (output, 16) and alu_f (output, 5), registered operands/function driving the external ALU.
REQ-010 SHALL have port alu_s, input, 16, combinational ALU result.
REQ-011 SHALL have ports top (output, 16, stack top, 0 when empty) and depth (output, DEPTH_LOG2+1, entry count).
REQ-012 SHALL have ports done (output, 1, one-cycle pulse per accepted command), err (output, 1, sticky fault flag) and err_clr (input, 1, clears err).

Function
REQ-013 SHALL implement FSM states IDLE, CALC, WB; cmd_ready = 1 only in IDLE.
REQ-014 PUSH accepted at edge T SHALL write cmd_data at index depth and increment depth at T; done high the cycle after T.
REQ-015 POP SHALL decrement depth at T; NOP SHALL change nothing but pulse done.
REQ-016 EXEC binary at T SHALL load alu_a = top, alu_b = entry below top, alu_f = cmd_func, go to CALC.
REQ-017 EXEC unary at T SHALL load alu_a = top, alu_b = 0, alu_f = cmd_func.
REQ-018 In CALC, edge T+1 SHALL capture alu_s into an internal result register and go to WB.
REQ-019 In WB, edge T+2 SHALL write result: binary replaces the two operands (depth-1, result at new top); unary replaces top (depth unchanged); return to IDLE; done high the cycle after T+2.
REQ-020 Next command SHALL be acceptable no earlier than edge T+3 after an EXEC.
REQ-021 Faults SHALL be detected at acceptance edge T: PUSH with depth = 2^DEPTH_LOG2 (overflow); POP/unary with depth 0; binary with depth < 2 (underflow); illegal cmd_op or cmd_func.
REQ-022 On fault SHALL set err, leave stack, depth and alu_* unchanged, stay in IDLE, and still pulse done the next cycle.
REQ-023 err SHALL clear on err_clr at a clock edge; a fault at the same edge as err_clr SHALL win (err stays 1).
REQ-024 depth SHALL never wrap; full and empty are fault boundaries, not wrap points.
REQ-025 Width rule: result and stack entries are 16 bits; no sign or carry state is kept by this block.

Reset
REQ-026 On rst, asynchronously: state IDLE, depth 0, top 0, alu_a/alu_b 0, alu_f 0, done 0, err 0; cmd_ready 1 once rst deasserts.
REQ-027 rst during CALC or WB SHALL abort the EXEC with no write-back and no done pulse.
REQ-028 Stack memory contents need not be cleared; top SHALL read 0 whenever depth is 0.

Configuration
REQ-029 Macro STACK_EXEC_DUP_EN: when defined, cmd_op 100 (DUP) SHALL push a copy of top in one cycle, faulting on empty or full; when undefined, 100 SHALL be an illegal opcode (err set, no change).

Verification
REQ-030 PUSH 5, PUSH 3, EXEC 00001 (SUB) -> alu_a=3, alu_b=5 after T; done 3 cycles after T; depth=1, top=0x0002.
REQ-031 PUSH 1, EXEC 10000 (NEG) -> top=0xFFFF, depth=1; cmd_ready low exactly two cycles.
REQ-032 16 PUSHes of 0..15 -> depth=16, top=15; 17th PUSH -> err=1, depth=16, top=15.
REQ-033 depth=1, EXEC 00000 (ADD) -> err=1, done pulse, top and depth unchanged; err_clr -> err=0.
REQ-034 PUSH 7, PUSH 2, EXEC ADD, assert rst in the CALC cycle -> depth=0, top=0, no done, cmd_ready=1 after release.
REQ-035 With STACK_EXEC_DUP_EN: PUSH 0x1234, DUP -> depth=2, top=0x1234; without it: DUP -> err=1, depth=1.

Source files
------------

// File: rtl/stack_exec.sv
// rtl/stack_exec.sv - operand-stack command executor driving an external combinational ALU
//
// Purpose:
//   Holds a 2^DEPTH_LOG2-entry stack of 16-bit words. It accepts one command
//   at a time: NOP, PUSH, POP, EXEC or DUP. EXEC sends operands to an external
//   ALU and writes the ALU result back. Illegal or out-of-range commands are
//   rejected without changing any state. They set a sticky error flag.
//
// Parameters:
//   DEPTH_LOG2 - log2 of the number of stack entries
//
// Build option:
//   STACK_EXEC_DUP_EN - when defined, opcode 100 (DUP) pushes a copy of top.
//                       When undefined, opcode 100 is illegal.
//
// Ports:
//   clk, rst              - clock and asynchronous active-high reset
//   cmd_valid/cmd_ready   - command handshake; ready only when idle
//   cmd_op, cmd_data      - opcode and PUSH operand
//   cmd_func              - ALU function for EXEC (0-15 binary, 16-18 unary)
//   alu_a, alu_b, alu_f   - registered operands/function to the external ALU
//   alu_s                 - combinational ALU result
//   top, depth            - current stack top (0 when empty) and entry count
//   done                  - one-cycle pulse per accepted command
//   err, err_clr          - sticky fault flag and its clear

module stack_exec #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [15:0]           cmd_data,
    input  logic [4:0]            cmd_func,
    output logic [15:0]           alu_a,
    output logic [15:0]           alu_b,
    output logic [4:0]            alu_f,
    input  logic [15:0]           alu_s,
    output logic [15:0]           top,
    output logic [DEPTH_LOG2:0]   depth,
    output logic                  done,
    output logic                  err,
    input  logic                  err_clr
);

    localparam int ENTRIES = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_EXEC = 3'b011;
    localparam logic [2:0] OP_DUP  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state, state_d;

    logic [15:0] mem [0:ENTRIES-1];

    logic [DEPTH_LOG2:0]   depth_d;
    logic [15:0]           alu_a_d, alu_b_d, result, result_d;
    logic [4:0]            alu_f_d;
    logic                  done_d, err_d, fault;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [15:0]           wr_data;

    logic [DEPTH_LOG2:0]   depth_m1, depth_m2;
    logic [DEPTH_LOG2-1:0] top_idx, below_idx;
    logic                  is_empty, is_full;

    assign depth_m1  = depth - 1'b1;
    assign depth_m2  = depth - 2'd2;
    assign top_idx   = depth_m1[DEPTH_LOG2-1:0];
    assign below_idx = depth_m2[DEPTH_LOG2-1:0];
    assign is_empty  = (depth == '0);
    assign is_full   = (depth == DEPTH_FULL);

    // Stale memory contents are never exposed. An empty stack reads as zero.
    assign top       = is_empty ? 16'h0000 : mem[top_idx];
    assign cmd_ready = (state == IDLE);

    always_comb begin
        state_d  = state;
        depth_d  = depth;
        alu_a_d  = alu_a;
        alu_b_d  = alu_b;
        alu_f_d  = alu_f;
        result_d = result;
        done_d   = 1'b0;
        fault    = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = depth[DEPTH_LOG2-1:0];
        wr_data  = cmd_data;
        err_d    = err_clr ? 1'b0 : err;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    done_d = 1'b1;
                    case (cmd_op)
                        OP_NOP: ;
                        OP_PUSH: begin
                            if (is_full) begin
                                fault = 1'b1;
                            end else begin
                                wr_en   = 1'b1;
                                depth_d = depth + 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (is_empty) fault = 1'b1;
                            else          depth_d = depth_m1;
                        end
                        OP_EXEC: begin
                            if (cmd_func < 5'd16) begin
                                if (depth < 2) begin
                                    fault = 1'b1;
                                end else begin
                                    alu_a_d = top;
                                    alu_b_d = mem[below_idx];
                                    alu_f_d = cmd_func;
                                    state_d = CALC;
                                    done_d  = 1'b0;
                                end
                            end else if (cmd_func <= 5'd18) begin
                                if (is_empty) begin
                                    fault = 1'b1;
                                end else begin
                                    alu_a_d = top;
                                    alu_b_d = 16'h0000;
                                    alu_f_d = cmd_func;
                                    state_d = CALC;
                                    done_d  = 1'b0;
                                end
                            end else begin
                                fault = 1'b1;
                            end
                        end
`ifdef STACK_EXEC_DUP_EN
                        OP_DUP: begin
                            if (is_empty || is_full) begin
                                fault = 1'b1;
                            end else begin
                                wr_en   = 1'b1;
                                wr_data = top;
                                depth_d = depth + 1'b1;
                            end
                        end
`endif
                        default: fault = 1'b1;
                    endcase
                    // A rejected command keeps all state. Its fault overrides
                    // an err_clr that arrives on the same edge.
                    if (fault) begin
                        wr_en   = 1'b0;
                        depth_d = depth;
                        err_d   = 1'b1;
                    end
                end
            end
            CALC: begin
                result_d = alu_s;
                state_d  = WB;
            end
            WB: begin
                wr_en   = 1'b1;
                wr_data = result;
                done_d  = 1'b1;
                state_d = IDLE;
                // alu_f[4] clear means binary: two operands collapse into one slot.
                if (!alu_f[4]) begin
                    wr_idx  = below_idx;
                    depth_d = depth_m1;
                end else begin
                    wr_idx  = top_idx;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            depth  <= '0;
            alu_a  <= 16'h0000;
            alu_b  <= 16'h0000;
            alu_f  <= 5'd0;
            result <= 16'h0000;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_d;
            depth  <= depth_d;
            alu_a  <= alu_a_d;
            alu_b  <= alu_b_d;
            alu_f  <= alu_f_d;
            result <= result_d;
            done   <= done_d;
            err    <= err_d;
        end
    end

    // The stack array is not reset. Gating the write with rst means a
    // write-back in progress is discarded when reset arrives.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_stack_exec.sv
// tb/tb_stack_exec.sv - directed self-checking bench for stack_exec
`timescale 1ns/1ps

module tb_stack_exec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [15:0] cmd_data = 16'h0;
    logic [4:0]  cmd_func = 5'd0;
    logic [15:0] alu_a, alu_b, alu_s, top;
    logic [4:0]  alu_f;
    logic [4:0]  depth;
    logic        done, err;
    logic        err_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    stack_exec #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_func(cmd_func),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_s(alu_s),
        .top(top), .depth(depth),
        .done(done), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // External ALU model: SUB is second-from-top minus top.
    always_comb begin
        case (alu_f)
            5'd0:    alu_s = alu_b + alu_a;
            5'd1:    alu_s = alu_b - alu_a;
            5'd16:   alu_s = -alu_a;
            5'd17:   alu_s = ~alu_a;
            5'd18:   alu_s = {15'h0, (alu_a == 16'h0)};
            default: alu_s = 16'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called 1ns after an edge. Returns 1ns after the acceptance edge T.
    task automatic send(input logic [2:0] op, input logic [15:0] data, input logic [4:0] func);
        int waits = 0;
        cmd_op = op; cmd_data = data; cmd_func = func; cmd_valid = 1'b1;
        while (!cmd_ready && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        chk("ready_before_cmd", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic clear_err;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_cleared", err, 0);
    endtask

    initial begin
        #2;
        chk("rst_depth", depth, 0);
        chk("rst_top", top, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_f", alu_f, 0);
        @(negedge clk); rst = 1'b0;
        step();
        chk("ready_after_rst", cmd_ready, 1);

        // PUSH 5, PUSH 3, EXEC SUB
        send(3'b001, 16'h0005, 5'd0);
        chk("push5_done", done, 1);
        chk("push5_depth", depth, 1);
        chk("push5_top", top, 16'h0005);
        send(3'b001, 16'h0003, 5'd0);
        chk("push3_depth", depth, 2);
        send(3'b011, 16'h0, 5'd1);
        chk("sub_alu_a", alu_a, 16'h0003);
        chk("sub_alu_b", alu_b, 16'h0005);
        chk("sub_alu_f", alu_f, 1);
        chk("sub_t_done", done, 0);
        chk("sub_t_ready", cmd_ready, 0);
        step();
        chk("sub_t1_done", done, 0);
        chk("sub_t1_ready", cmd_ready, 0);
        step();
        chk("sub_t2_done", done, 1);
        chk("sub_t2_ready", cmd_ready, 1);
        chk("sub_depth", depth, 1);
        chk("sub_top", top, 16'h0002);
        step();
        chk("sub_done_pulse_end", done, 0);
        send(3'b010, 16'h0, 5'd0);
        chk("pop_depth", depth, 0);
        chk("pop_top_empty", top, 0);

        // PUSH 1, EXEC NEG
        send(3'b001, 16'h0001, 5'd0);
        send(3'b011, 16'h0, 5'd16);
        chk("neg_alu_b", alu_b, 0);
        chk("neg_ready_c1", cmd_ready, 0);
        step();
        chk("neg_ready_c2", cmd_ready, 0);
        step();
        chk("neg_ready_back", cmd_ready, 1);
        chk("neg_top", top, 16'hFFFF);
        chk("neg_depth", depth, 1);
        send(3'b010, 16'h0, 5'd0);

        // Fill to the top, then overflow
        for (int i = 0; i < 16; i++) send(3'b001, 16'(i), 5'd0);
        chk("full_depth", depth, 16);
        chk("full_top", top, 15);
        chk("full_err_before", err, 0);
        send(3'b001, 16'hAAAA, 5'd0);
        chk("ovf_err", err, 1);
        chk("ovf_done", done, 1);
        chk("ovf_depth", depth, 16);
        chk("ovf_top", top, 15);
        clear_err();
        err_clr = 1'b1;
        send(3'b001, 16'hBBBB, 5'd0);
        err_clr = 1'b0;
        chk("fault_beats_clr", err, 1);
        clear_err();

        // Unary and binary EXEC on a full stack
        send(3'b011, 16'h0, 5'd17);
        step(); step();
        chk("bnot_top", top, 16'hFFF0);
        chk("bnot_depth", depth, 16);
        send(3'b011, 16'h0, 5'd0);
        chk("add_full_alu_a", alu_a, 16'hFFF0);
        chk("add_full_alu_b", alu_b, 16'h000E);
        step(); step();
        chk("add_full_top", top, 16'hFFFE);
        chk("add_full_depth", depth, 15);
        for (int i = 0; i < 15; i++) send(3'b010, 16'h0, 5'd0);
        chk("drain_depth", depth, 0);
        chk("drain_top", top, 0);
        send(3'b010, 16'h0, 5'd0);
        chk("udf_pop_err", err, 1);
        chk("udf_pop_depth", depth, 0);
        clear_err();

        // Binary EXEC with one entry
        send(3'b001, 16'h0009, 5'd0);
        send(3'b011, 16'h0, 5'd0);
        chk("udf_add_err", err, 1);
        chk("udf_add_done", done, 1);
        chk("udf_add_ready", cmd_ready, 1);
        chk("udf_add_top", top, 16'h0009);
        chk("udf_add_depth", depth, 1);
        chk("udf_add_alu_a", alu_a, 16'hFFF0);
        chk("udf_add_alu_f", alu_f, 0);
        clear_err();
        send(3'b011, 16'h0, 5'd18);
        step(); step();
        chk("not_top", top, 16'h0000);
        chk("not_depth", depth, 1);
        send(3'b011, 16'h0, 5'd19);
        chk("bad_func_err", err, 1);
        chk("bad_func_depth", depth, 1);
        clear_err();
        send(3'b111, 16'h0, 5'd0);
        chk("bad_op_err", err, 1);
        clear_err();
        send(3'b000, 16'h0, 5'd0);
        chk("nop_done", done, 1);
        chk("nop_depth", depth, 1);
        chk("nop_err", err, 0);
        send(3'b010, 16'h0, 5'd0);

        // DUP
        send(3'b001, 16'h1234, 5'd0);
        send(3'b100, 16'h0, 5'd0);
`ifdef STACK_EXEC_DUP_EN
        chk("dup_depth", depth, 2);
        chk("dup_top", top, 16'h1234);
        chk("dup_err", err, 0);
`else
        chk("dup_illegal_err", err, 1);
        chk("dup_illegal_depth", depth, 1);
        chk("dup_illegal_top", top, 16'h1234);
`endif

        // Reset in the CALC cycle aborts the EXEC
        rst = 1'b1;
        #1;
        chk("rst2_depth", depth, 0);
        chk("rst2_err", err, 0);
        @(negedge clk); rst = 1'b0;
        step();
        send(3'b001, 16'h0007, 5'd0);
        send(3'b001, 16'h0002, 5'd0);
        send(3'b011, 16'h0, 5'd0);
        chk("abort_in_calc_ready", cmd_ready, 0);
        rst = 1'b1;
        #1;
        chk("abort_depth", depth, 0);
        chk("abort_top", top, 0);
        chk("abort_done", done, 0);
        step();
        chk("abort_done_t1", done, 0);
        step();
        chk("abort_done_t2", done, 0);
        @(negedge clk); rst = 1'b0;
        step();
        chk("abort_ready", cmd_ready, 1);
        chk("abort_done_after", done, 0);
        chk("abort_depth_after", depth, 0);
        send(3'b001, 16'h0004, 5'd0);
        chk("post_abort_depth", depth, 1);
        chk("post_abort_top", top, 16'h0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
